// File: rtl/ddr_read_sequencer_if.sv
// Request, capture-buffer and status signals of the DQS read-burst sequencer.
// Request handshake: a request transfers on a rising SCLK edge where REQ_VALID and REQ_READY are both 1; the requester holds REQ_VALID/REQ_LEN stable until then.
interface ddr_read_sequencer_if;
  logic       REQ_VALID;
  logic [3:0] REQ_LEN;
  logic       REQ_READY;
  logic       READ;
  logic       DATAVALID;
  logic       DDRCLKPOL;
  logic       BEAT_VALID;
  logic       BEAT_LAST;
  logic       DONE;
  logic       TIMEOUT_ERR;
  logic       STRAY;
  logic       POL;
  logic       POL_CHANGE;

  modport master (
    output REQ_VALID, REQ_LEN, DATAVALID, DDRCLKPOL,
    input  REQ_READY, READ, BEAT_VALID, BEAT_LAST, DONE, TIMEOUT_ERR, STRAY, POL, POL_CHANGE
  );

  modport slave (
    input  REQ_VALID, REQ_LEN, DATAVALID, DDRCLKPOL,
    output REQ_READY, READ, BEAT_VALID, BEAT_LAST, DONE, TIMEOUT_ERR, STRAY, POL, POL_CHANGE
  );
endinterface

// File: rtl/ddr_read_sequencer.sv
// Read-burst sequencer for the ECP3 DQS capture buffer: opens the READ window with a
// programmable lead/tail, counts DATAVALID beats, aborts on a beat gap and tracks DDRCLKPOL.
module ddr_read_sequencer #(
  parameter int unsigned READ_LEAD = 4,
  parameter int unsigned READ_TAIL = 2,
  parameter int unsigned TIMEOUT   = 32
) (
  input  logic                       SCLK,
  input  logic                       RST,
  ddr_read_sequencer_if.slave        bus,
  output logic [2:0]                 dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEAD = 3'd1,
    S_WAIT = 3'd2,
    S_CAPT = 3'd3,
    S_TAIL = 3'd4
  } state_t;

  localparam logic [3:0] LEAD_LD  = 4'(READ_LEAD);
  localparam logic [3:0] TAIL_LD  = 4'(READ_TAIL);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] timer_q, timer_d;
  logic [4:0] len_q, len_d;
  logic [4:0] beats_q, beats_d;
  logic [4:0] beat_inc;
  logic       ready_q, ready_d;
  logic       read_q, read_d;
  logic       beat_valid_q, beat_valid_d;
  logic       beat_last_q, beat_last_d;
  logic       done_q, done_d;
  logic       tmo_q, tmo_d;
  logic       stray_q, stray_d;
  logic       pol_q, pol_d;
  logic       pol_valid_q, pol_valid_d;
  logic       pol_change_q, pol_change_d;

  assign beat_inc = beats_q + 5'd1;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    timer_d      = timer_q;
    len_d        = len_q;
    beats_d      = beats_q;
    ready_d      = ready_q;
    read_d       = read_q;
    pol_d        = pol_q;
    pol_valid_d  = pol_valid_q;
    beat_valid_d = 1'b0;
    beat_last_d  = 1'b0;
    done_d       = 1'b0;
    tmo_d        = 1'b0;
    stray_d      = 1'b0;
    pol_change_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Ready rises one edge after reset or an abort, so it lags the IDLE entry there.
        ready_d = 1'b1;
        read_d  = 1'b0;
        stray_d = bus.DATAVALID;
        if (bus.REQ_VALID && ready_q) begin
          state_d = S_LEAD;
          len_d   = (bus.REQ_LEN == 4'd0) ? 5'd16 : {1'b0, bus.REQ_LEN};
          beats_d = 5'd0;
          cnt_d   = LEAD_LD;
          ready_d = 1'b0;
          read_d  = 1'b1;
        end
      end
      S_LEAD: begin
        stray_d = bus.DATAVALID;
        if (cnt_q == 4'd1) begin
          state_d = S_WAIT;
          timer_d = 8'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WAIT, S_CAPT: begin
        // A beat on the expiry edge still counts: the beat check has priority over the timer.
        if (bus.DATAVALID) begin
          beat_valid_d = 1'b1;
          beats_d      = beat_inc;
          timer_d      = 8'd0;
          if (state_q == S_WAIT) begin
            state_d      = S_CAPT;
            pol_d        = bus.DDRCLKPOL;
            pol_valid_d  = 1'b1;
            pol_change_d = pol_valid_q && (bus.DDRCLKPOL != pol_q);
          end
          if (beat_inc == len_q) begin
            beat_last_d = 1'b1;
            state_d     = S_TAIL;
            cnt_d       = TAIL_LD;
          end
        end else if (timer_q == TMO_LAST) begin
          state_d = S_IDLE;
          read_d  = 1'b0;
          tmo_d   = 1'b1;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_TAIL: begin
        stray_d = bus.DATAVALID;
        if (cnt_q == 4'd0) begin
          state_d = S_IDLE;
          read_d  = 1'b0;
          ready_d = 1'b1;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        read_d  = 1'b0;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge SCLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      timer_q      <= 8'd0;
      len_q        <= 5'd0;
      beats_q      <= 5'd0;
      ready_q      <= 1'b0;
      read_q       <= 1'b0;
      beat_valid_q <= 1'b0;
      beat_last_q  <= 1'b0;
      done_q       <= 1'b0;
      tmo_q        <= 1'b0;
      stray_q      <= 1'b0;
      pol_q        <= 1'b0;
      pol_valid_q  <= 1'b0;
      pol_change_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      timer_q      <= timer_d;
      len_q        <= len_d;
      beats_q      <= beats_d;
      ready_q      <= ready_d;
      read_q       <= read_d;
      beat_valid_q <= beat_valid_d;
      beat_last_q  <= beat_last_d;
      done_q       <= done_d;
      tmo_q        <= tmo_d;
      stray_q      <= stray_d;
      pol_q        <= pol_d;
      pol_valid_q  <= pol_valid_d;
      pol_change_q <= pol_change_d;
    end
  end

  assign bus.REQ_READY   = ready_q;
  assign bus.READ        = read_q;
  assign bus.BEAT_VALID  = beat_valid_q;
  assign bus.BEAT_LAST   = beat_last_q;
  assign bus.DONE        = done_q;
  assign bus.TIMEOUT_ERR = tmo_q;
  assign bus.STRAY       = stray_q;
  assign bus.POL         = pol_q;
  assign bus.POL_CHANGE  = pol_change_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_ddr_read_sequencer.sv
// Directed bench for ddr_read_sequencer: inputs driven and outputs sampled on the falling edge.
module tb_ddr_read_sequencer;
  localparam int unsigned READ_LEAD = 4;
  localparam int unsigned READ_TAIL = 2;
  localparam int unsigned TIMEOUT   = 32;
  localparam int W = 8;

  logic       SCLK;
  logic       RST;
  logic [2:0] dbg_state;

  ddr_read_sequencer_if bus();

  ddr_read_sequencer #(
    .READ_LEAD(READ_LEAD),
    .READ_TAIL(READ_TAIL),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .SCLK     (SCLK),
    .RST      (RST),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial SCLK = 1'b0;
  always #5 SCLK = ~SCLK;

  int tests = 0;
  int fails = 0;
  int n_beat = 0, n_last = 0, n_done = 0, n_tmo = 0, n_stray = 0, n_chg = 0;
  int b0, l0, d0, t0, s0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(negedge SCLK);
    if (bus.BEAT_VALID === 1'b1)  n_beat++;
    if (bus.BEAT_LAST === 1'b1)   n_last++;
    if (bus.DONE === 1'b1)        n_done++;
    if (bus.TIMEOUT_ERR === 1'b1) n_tmo++;
    if (bus.STRAY === 1'b1)       n_stray++;
    if (bus.POL_CHANGE === 1'b1)  n_chg++;
  endtask

  task automatic issue(input logic [3:0] len);
    bus.REQ_VALID = 1'b1;
    bus.REQ_LEN   = len;
    step();
    bus.REQ_VALID = 1'b0;
    check("accept_read_ready", {6'd0, bus.READ, bus.REQ_READY}, 8'b10);
  endtask

  task automatic lead_wait(input int n);
    repeat (n) step();
  endtask

  task automatic snap();
    b0 = n_beat; l0 = n_last; d0 = n_done; t0 = n_tmo; s0 = n_stray;
  endtask

  // full burst, first-beat POL checked against the scoreboard queue
  task automatic run_burst(input logic [3:0] len, input logic pol, input logic exp_chg);
    int n;
    logic [W-1:0] exp_pol;
    n = (len == 4'd0) ? 16 : int'(len);
    snap();
    issue(len);
    lead_wait(READ_LEAD);
    bus.DDRCLKPOL = pol;
    bus.DATAVALID = 1'b1;
    for (int i = 0; i < n; i++) begin
      step();
      if (i == 0) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $error("FAIL pol_queue: observed empty expected entry");
        end else begin
          exp_pol = exp_q.pop_front();
          check("pol", {7'd0, bus.POL}, exp_pol);
          check("pol_change", {7'd0, bus.POL_CHANGE}, {7'd0, exp_chg});
        end
      end
      check("beat_valid_last", {6'd0, bus.BEAT_VALID, bus.BEAT_LAST}, (i == n - 1) ? 8'b11 : 8'b10);
    end
    bus.DATAVALID = 1'b0;
    repeat (READ_TAIL) step();
    check("tail_read_high", {7'd0, bus.READ}, 8'd1);
    step();
    check("done_read_ready", {5'd0, bus.READ, bus.DONE, bus.REQ_READY}, 8'b011);
    check("burst_beats", 8'(n_beat - b0), 8'(n));
    check("burst_done_once", 8'(n_done - d0), 8'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    bus.REQ_VALID = 1'b0;
    bus.REQ_LEN   = 4'd0;
    bus.DATAVALID = 1'b0;
    bus.DDRCLKPOL = 1'b0;
    repeat (3) step();
    check("reset_outputs", {bus.REQ_READY, bus.READ, bus.BEAT_VALID, bus.BEAT_LAST, bus.DONE,
                            bus.TIMEOUT_ERR, bus.STRAY, bus.POL}, 8'd0);
    check("reset_pol_change", {7'd0, bus.POL_CHANGE}, 8'd0);
    check("reset_state", {5'd0, dbg_state}, 8'd0);
    RST = 1'b0;
    step();
    check("ready_after_reset", {7'd0, bus.REQ_READY}, 8'd1);

    // len=4 basic burst, then back-to-back 16-beat burst
    exp_q.push_back(8'd0);
    run_burst(4'd4, 1'b0, 1'b0);
    exp_q.push_back(8'd0);
    run_burst(4'd0, 1'b0, 1'b0);

    // no beat ever: abort exactly TIMEOUT cycles after entering WAIT
    snap();
    issue(4'd2);
    lead_wait(READ_LEAD);
    repeat (TIMEOUT - 1) step();
    check("wait_before_expiry", {6'd0, bus.READ, bus.TIMEOUT_ERR}, 8'b10);
    step();
    check("timeout_pulse", {5'd0, bus.READ, bus.TIMEOUT_ERR, bus.REQ_READY}, 8'b010);
    step();
    check("timeout_ready_next", {6'd0, bus.TIMEOUT_ERR, bus.REQ_READY}, 8'b01);
    check("timeout_no_done", 8'(n_done - d0), 8'd0);
    check("timeout_no_last", 8'(n_last - l0), 8'd0);

    // len=3 with a 10-cycle gap between beats 2 and 3
    snap();
    issue(4'd3);
    lead_wait(READ_LEAD);
    bus.DATAVALID = 1'b1;
    step(); step();
    bus.DATAVALID = 1'b0;
    repeat (10) step();
    bus.DATAVALID = 1'b1;
    step();
    check("gap10_last_beat", {6'd0, bus.BEAT_VALID, bus.BEAT_LAST}, 8'b11);
    bus.DATAVALID = 1'b0;
    repeat (READ_TAIL + 1) step();
    check("gap10_done", {7'd0, bus.DONE}, 8'd1);
    check("gap10_no_timeout", 8'(n_tmo - t0), 8'd0);

    // beats landing exactly on the expiry edge, twice in a row
    snap();
    issue(4'd3);
    lead_wait(READ_LEAD);
    bus.DATAVALID = 1'b1;
    step();
    bus.DATAVALID = 1'b0;
    repeat (TIMEOUT - 1) step();
    bus.DATAVALID = 1'b1;
    step();
    check("expiry_beat2", {5'd0, bus.BEAT_VALID, bus.BEAT_LAST, bus.TIMEOUT_ERR}, 8'b100);
    bus.DATAVALID = 1'b0;
    repeat (TIMEOUT - 1) step();
    bus.DATAVALID = 1'b1;
    step();
    check("expiry_beat3", {5'd0, bus.BEAT_VALID, bus.BEAT_LAST, bus.TIMEOUT_ERR}, 8'b110);
    bus.DATAVALID = 1'b0;
    repeat (READ_TAIL + 1) step();
    check("expiry_done", {6'd0, bus.DONE, bus.READ}, 8'b10);
    check("expiry_no_timeout", 8'(n_tmo - t0), 8'd0);

    // gap of TIMEOUT cycles inside CAPT aborts
    snap();
    issue(4'd2);
    lead_wait(READ_LEAD);
    bus.DATAVALID = 1'b1;
    step();
    bus.DATAVALID = 1'b0;
    repeat (TIMEOUT) step();
    check("gap_abort", {5'd0, bus.READ, bus.TIMEOUT_ERR, bus.BEAT_LAST}, 8'b010);
    step();
    check("gap_abort_ready", {7'd0, bus.REQ_READY}, 8'd1);
    check("gap_abort_no_done", 8'(n_done - d0), 8'd0);

    // polarity tracking across bursts
    exp_q.push_back(8'd1);
    run_burst(4'd2, 1'b1, 1'b1);
    exp_q.push_back(8'd1);
    run_burst(4'd1, 1'b1, 1'b0);
    exp_q.push_back(8'd0);
    run_burst(4'd1, 1'b0, 1'b1);

    // stray DATAVALID in IDLE and in LEAD
    snap();
    bus.DATAVALID = 1'b1;
    step();
    check("stray_idle", {6'd0, bus.STRAY, bus.BEAT_VALID}, 8'b10);
    bus.DATAVALID = 1'b0;
    issue(4'd1);
    bus.DATAVALID = 1'b1;
    step();
    check("stray_lead", {6'd0, bus.STRAY, bus.BEAT_VALID}, 8'b10);
    bus.DATAVALID = 1'b0;
    lead_wait(READ_LEAD - 1);
    check("stray_no_beats", 8'(n_beat - b0), 8'd0);
    check("stray_count", 8'(n_stray - s0), 8'd2);
    bus.DATAVALID = 1'b1;
    step();
    check("after_stray_beat", {5'd0, bus.BEAT_VALID, bus.BEAT_LAST, bus.POL_CHANGE}, 8'b110);
    bus.DATAVALID = 1'b0;
    repeat (READ_TAIL + 1) step();
    check("after_stray_done", {7'd0, bus.DONE}, 8'd1);

    // reset in the middle of CAPT
    snap();
    issue(4'd4);
    lead_wait(READ_LEAD);
    bus.DATAVALID = 1'b1;
    step(); step();
    bus.DATAVALID = 1'b0;
    RST = 1'b1;
    step();
    check("mid_reset_outputs", {3'd0, bus.READ, bus.DONE, bus.TIMEOUT_ERR, bus.BEAT_LAST, bus.REQ_READY}, 8'd0);
    check("mid_reset_pol", {7'd0, bus.POL}, 8'd0);
    RST = 1'b0;
    step();
    check("mid_reset_ready", {7'd0, bus.REQ_READY}, 8'd1);
    check("mid_reset_no_done_tmo", 8'((n_done - d0) + (n_tmo - t0) + (n_last - l0)), 8'd0);
    exp_q.push_back(8'd1);
    run_burst(4'd3, 1'b1, 1'b0);

    check("exp_q_drained", 8'(exp_q.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ddr_read_sequencer.md
# ddr_read_sequencer

Read-burst controller that sequences the ECP3 DQS read-capture buffer. It accepts read requests from the memory controller front end and drives the buffer's READ window with a programmable lead and tail. It counts DATAVALID beats, flags missing or stray beats, and tracks the DDRCLKPOL decision from one burst to the next. It sits between the command scheduler and the per-DQS-group capture buffer, in the SCLK domain.

## Interface
- READ_LEAD, 4: cycles READ is high before beats are accepted (1..15).
- READ_TAIL, 2: cycles READ stays high after the last beat (1..15).
- TIMEOUT, 32: maximum cycles without a beat while a beat is awaited (2..255).

- SCLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  synchronous reset, active-high.
- REQ_VALID  in  1  read request present.
- REQ_LEN  in  4  burst length in SCLK-rate beats; 0 encodes 16.
- REQ_READY  out  1  sequencer can accept a request.
- READ  out  1  read window to the capture buffer.
- DATAVALID  in  1  beat-valid flag from the capture buffer.
- DDRCLKPOL  in  1  clock-polarity decision from the capture buffer.
- BEAT_VALID  out  1  registered beat strobe.
- BEAT_LAST  out  1  final beat of the burst; only with BEAT_VALID.
- DONE  out  1  one-cycle pulse: burst completed.
- TIMEOUT_ERR  out  1  one-cycle pulse: burst aborted.
- STRAY  out  1  one-cycle pulse: DATAVALID seen outside the beat window.
- POL  out  1  DDRCLKPOL sampled at the first beat of the latest burst.
- POL_CHANGE  out  1  one-cycle pulse: POL differs from the previous burst's value.

## Operation
- States:
  - IDLE: READ=0, REQ_READY=1.
  - LEAD: READ=1; DATAVALID is not a beat.
  - WAIT: READ=1; awaiting the first beat.
  - CAPT: READ=1; beats after the first.
  - TAIL: READ=1.
  - IDLE follows TAIL or an abort.
- Acceptance: REQ_VALID & REQ_READY at an edge.
  - Latch len (0→16) into a 5-bit register and clear the beat counter.
  - Next state LEAD; lead counter loads READ_LEAD.
  - REQ_VALID outside IDLE is ignored; the request is held by the requester.
- LEAD → WAIT after exactly READ_LEAD cycles in LEAD.
- Beat: DATAVALID=1 sampled in WAIT or CAPT.
  - Increment the beat counter and reset the gap timer.
  - First beat: WAIT → CAPT; sample DDRCLKPOL into POL.
  - POL_CHANGE pulses if the new POL differs from the prior POL. The first burst after reset never pulses.
  - Beat count == len: assert BEAT_LAST with that beat and go to TAIL (also from WAIT when len=1).
- Gaps inside CAPT are allowed; DATAVALID=0 cycles do not abort until the timeout.
- Gap timer: 8-bit, counts cycles in WAIT/CAPT since entry to WAIT or since the last beat.
  - Timer reaching TIMEOUT with no beat on that edge: go to IDLE, READ=0, TIMEOUT_ERR pulse.
  - No BEAT_LAST and no DONE for an aborted burst.
- TAIL lasts READ_TAIL cycles, then IDLE with a DONE pulse.
- STRAY pulses for a DATAVALID=1 sample in IDLE, LEAD or TAIL. State is unaffected.

## Timing
- Reset: while RST=1, all outputs are 0 and state is IDLE.
  - POL=0 and the "POL valid" flag is cleared.
  - REQ_READY rises on the first edge after RST falls.
- All outputs are registered; no combinational input-to-output paths.
- Accept at edge E0: READ=1 and REQ_READY=0 from E0.
  - First edge that may capture a beat: E0+READ_LEAD+1.
- BEAT_VALID (and BEAT_LAST) is high for the one cycle after the edge that sampled the beat: one cycle latency.
- Last beat sampled at edge Eb:
  - READ stays 1 through Eb+READ_TAIL.
  - At edge Eb+READ_TAIL+1: READ=0, DONE=1 and REQ_READY=1, all in the same cycle.
- Back-to-back: a request accepted in the DONE cycle starts LEAD on the following edge, so READ is low for exactly one cycle between bursts.
- Timeout at edge Et:
  - READ=0 and TIMEOUT_ERR=1 from Et for one cycle.
  - REQ_READY=1 from Et+1.
- Simultaneous DATAVALID=1 and timer==TIMEOUT: the beat wins and the timer clears.
- RST=1 mid-burst: READ drops on that edge; no DONE, TIMEOUT_ERR or BEAT_LAST is generated.
- POL and POL_CHANGE update with the first BEAT_VALID of a burst.

## Test plan
- Reset release, then a len=4 request (READ_LEAD=4, READ_TAIL=2); DATAVALID high at E0+5..E0+8 → four BEAT_VALID at E0+6..E0+9 with BEAT_LAST at E0+9; READ falls and DONE=1 at E0+11.
- REQ_LEN=0 with a continuous DATAVALID → 16 beats, BEAT_LAST on the 16th, one DONE.
- Request with DATAVALID never asserted (TIMEOUT=32) → TIMEOUT_ERR exactly 32 cycles after entering WAIT; READ=0; no DONE; REQ_READY=1 the next cycle.
- len=3 with a 10-cycle gap between beats 2 and 3 → no abort; a gap of TIMEOUT cycles → abort. DATAVALID=1 exactly on the expiry edge → beat accepted and timer cleared.
- Two bursts with DDRCLKPOL 0 then 1 → POL 0 then 1, and one POL_CHANGE at the second burst's first beat. DATAVALID pulsed in LEAD and in IDLE → STRAY twice, no beats.
- RST asserted during CAPT → READ=0 next cycle, no DONE or TIMEOUT_ERR; REQ_READY=1 one cycle after RST falls; the following burst completes normally.
